// File: rtl/ng_writeback_if.sv
// Bus bundles for ng_writeback.
//   ng_instr_if : the instruction and handler-result stream. The producer is the
//                 master and ng_writeback is the slave.
//   ng_memwr_if : the data-memory store port. ng_writeback is the master and the
//                 memory is the slave.
interface ng_instr_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [15:0] alu_out;
  logic        jmp;
  logic [2:0]  dst;

  modport master (output instr_valid, instruction, alu_out, jmp, dst, input instr_ready);
  modport slave  (input instr_valid, instruction, alu_out, jmp, dst, output instr_ready);
endinterface

interface ng_memwr_if;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;

  modport master (output mem_wr_valid, mem_wr_addr, mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_valid, mem_wr_addr, mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/ng_writeback.sv
// ng_writeback: register-commit and PC unit for the nandgame core.
// The unit commits A/D results and advances or redirects the PC. It issues *A
// stores over a valid/ready write port, and it holds off new instructions
// while a store is outstanding.
// Optional feature: define NGWB_RETIRE_CNT_EN to add a 16-bit wrapping
// retire_count output that counts retired pulses.
module ng_writeback #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  ng_instr_if.slave   instr,
  ng_memwr_if.master  mem,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic [15:0] pc,
`ifdef NGWB_RETIRE_CNT_EN
  output logic [15:0] retire_count,
`endif
  output logic        retired
);

  typedef enum logic {EXEC, STORE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] acc_a_reg, acc_a_next;
  logic [15:0] acc_d_reg, acc_d_next;
  logic [15:0] pc_reg, pc_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [15:0] wr_addr_reg, wr_addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic        retired_reg, retired_next;

  // State and architectural registers; reset wins over any accept or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EXEC;
      acc_a_reg    <= 16'h0000;
      acc_d_reg    <= 16'h0000;
      pc_reg       <= RESET_PC;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= 16'h0000;
      wr_data_reg  <= 16'h0000;
      retired_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_a_reg    <= acc_a_next;
      acc_d_reg    <= acc_d_next;
      pc_reg       <= pc_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      retired_reg  <= retired_next;
    end
  end

  // Next-state logic. Jump target and store address both use the A value from
  // before this instruction, even when the same instruction also writes A.
  always_comb begin
    state_next    = state_reg;
    acc_a_next    = acc_a_reg;
    acc_d_next    = acc_d_reg;
    pc_next       = pc_reg;
    wr_valid_next = wr_valid_reg;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    retired_next  = 1'b0;

    case (state_reg)
      EXEC: begin
        if (instr.instr_valid) begin
          if (!instr.instruction[15]) begin
            // A-load: the whole word is the constant, and jmp/dst are ignored.
            acc_a_next   = instr.instruction;
            pc_next      = pc_reg + 16'd1;
            retired_next = 1'b1;
          end else begin
            if (instr.dst[2]) acc_a_next = instr.alu_out;
            if (instr.dst[1]) acc_d_next = instr.alu_out;
            pc_next = instr.jmp ? acc_a_reg : (pc_reg + 16'd1);
            if (instr.dst[0]) begin
              wr_addr_next  = acc_a_reg;
              wr_data_next  = instr.alu_out;
              wr_valid_next = 1'b1;
              state_next    = STORE;
            end else begin
              retired_next = 1'b1;
            end
          end
        end
      end
      STORE: begin
        // Address and data stay put until memory takes the store.
        if (wr_valid_reg && mem.mem_wr_ready) begin
          wr_valid_next = 1'b0;
          state_next    = EXEC;
          retired_next  = 1'b1;
        end
      end
      default: state_next = EXEC;
    endcase
  end

`ifdef NGWB_RETIRE_CNT_EN
  logic [15:0] retire_cnt_reg;

  // Free-running retire counter that wraps modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= 16'h0000;
    end else if (retired_reg) begin
      retire_cnt_reg <= retire_cnt_reg + 16'd1;
    end
  end

  assign retire_count = retire_cnt_reg;
`endif

  assign instr.instr_ready = (state_reg == EXEC);
  assign mem.mem_wr_valid  = wr_valid_reg;
  assign mem.mem_wr_addr   = wr_addr_reg;
  assign mem.mem_wr_data   = wr_data_reg;
  assign a_reg             = acc_a_reg;
  assign d_reg             = acc_d_reg;
  assign pc                = pc_reg;
  assign retired           = retired_reg;

endmodule

// File: tb/tb_ng_writeback.sv
// Directed testbench for ng_writeback. The main instance uses RESET_PC=0.
// A second instance uses RESET_PC=16'hFFFF and covers PC wraparound.
module tb_ng_writeback;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ng_instr_if ib ();
  ng_memwr_if mb ();
  ng_instr_if ib_w ();
  ng_memwr_if mb_w ();

  logic [15:0] a_reg, d_reg, pc;
  logic        retired;
  logic [15:0] a_reg_w, d_reg_w, pc_w;
  logic        retired_w;
`ifdef NGWB_RETIRE_CNT_EN
  logic [15:0] retire_count, retire_count_w;
`endif

  ng_writeback #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .instr(ib.slave), .mem(mb.master),
    .a_reg(a_reg), .d_reg(d_reg), .pc(pc),
`ifdef NGWB_RETIRE_CNT_EN
    .retire_count(retire_count),
`endif
    .retired(retired)
  );

  ng_writeback #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .instr(ib_w.slave), .mem(mb_w.master),
    .a_reg(a_reg_w), .d_reg(d_reg_w), .pc(pc_w),
`ifdef NGWB_RETIRE_CNT_EN
    .retire_count(retire_count_w),
`endif
    .retired(retired_w)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Step one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] alu,
                       input logic j, input logic [2:0] d);
    ib.instr_valid = v;
    ib.instruction = ins;
    ib.alu_out     = alu;
    ib.jmp         = j;
    ib.dst         = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    mb.mem_wr_ready    = 1'b0;
    ib_w.instr_valid   = 1'b0;
    ib_w.instruction   = 16'h0000;
    ib_w.alu_out       = 16'h0000;
    ib_w.jmp           = 1'b0;
    ib_w.dst           = 3'b000;
    mb_w.mem_wr_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_a", a_reg, 16'h0000);
    check("rst_d", d_reg, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    check("rst_wr_valid", {15'd0, mb.mem_wr_valid}, 16'd0);
    check("rst_wr_addr", mb.mem_wr_addr, 16'h0000);
    check("rst_wr_data", mb.mem_wr_data, 16'h0000);
    check("rst_ready", {15'd0, ib.instr_ready}, 16'd1);
    check("rst_retired", {15'd0, retired}, 16'd0);
    check("wrap_rst_pc", pc_w, 16'hFFFF);
`ifdef NGWB_RETIRE_CNT_EN
    check("rst_retire_count", retire_count, 16'd0);
`endif

    // A-load of 0x1234
    drive(1'b1, 16'h1234, 16'h0000, 1'b0, 3'b000);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    check("aload_a", a_reg, 16'h1234);
    check("aload_pc", pc, 16'h0001);
    check("aload_retired", {15'd0, retired}, 16'd1);
    check("aload_no_store", {15'd0, mb.mem_wr_valid}, 16'd0);
    tick();
    check("aload_retired_single", {15'd0, retired}, 16'd0);

    // Load A=5, then a C-instruction that writes A and D and jumps to old A
    drive(1'b1, 16'h0005, 16'h0000, 1'b0, 3'b000);
    tick();
    drive(1'b1, 16'h8000, 16'h00AA, 1'b1, 3'b110);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    check("cad_a", a_reg, 16'h00AA);
    check("cad_d", d_reg, 16'h00AA);
    check("cad_pc", pc, 16'h0005);
    check("cad_retired", {15'd0, retired}, 16'd1);

    // Idle cycles hold state
    tick();
    tick();
    check("idle_a", a_reg, 16'h00AA);
    check("idle_pc", pc, 16'h0005);

    // Store with dual destination: A=0x10, dst=101, alu=0x77, three wait cycles
    drive(1'b1, 16'h0010, 16'h0000, 1'b0, 3'b000);
    tick();                                    // pc=6
    drive(1'b1, 16'h8000, 16'h0077, 1'b0, 3'b101);
    tick();                                    // enter STORE, pc=7
    drive(1'b1, 16'h0999, 16'h0000, 1'b0, 3'b000);   // held by producer
    check("st_a", a_reg, 16'h0077);
    check("st_pc", pc, 16'h0007);
    check("st_valid", {15'd0, mb.mem_wr_valid}, 16'd1);
    check("st_addr", mb.mem_wr_addr, 16'h0010);
    check("st_data", mb.mem_wr_data, 16'h0077);
    check("st_ready", {15'd0, ib.instr_ready}, 16'd0);
    check("st_retired", {15'd0, retired}, 16'd0);
    for (int w = 0; w < 3; w++) begin
      tick();
      check($sformatf("st_wait%0d_valid", w), {15'd0, mb.mem_wr_valid}, 16'd1);
      check($sformatf("st_wait%0d_addr", w), mb.mem_wr_addr, 16'h0010);
      check($sformatf("st_wait%0d_data", w), mb.mem_wr_data, 16'h0077);
      check($sformatf("st_wait%0d_ready", w), {15'd0, ib.instr_ready}, 16'd0);
      check($sformatf("st_wait%0d_a", w), a_reg, 16'h0077);
      check($sformatf("st_wait%0d_retired", w), {15'd0, retired}, 16'd0);
    end
    mb.mem_wr_ready = 1'b1;
    tick();                                    // handshake edge
    check("hs_valid", {15'd0, mb.mem_wr_valid}, 16'd0);
    check("hs_retired", {15'd0, retired}, 16'd1);
    check("hs_ready", {15'd0, ib.instr_ready}, 16'd1);
    check("hs_a_held", a_reg, 16'h0077);
    tick();                                    // held A-load now accepted
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    check("post_a", a_reg, 16'h0999);
    check("post_pc", pc, 16'h0008);
    check("post_retired", {15'd0, retired}, 16'd1);
    check("post_valid_ready_hi", {15'd0, mb.mem_wr_valid}, 16'd0);

    // D-only, no jump
    drive(1'b1, 16'hE000, 16'h1357, 1'b0, 3'b010);
    tick();
    check("donly_d", d_reg, 16'h1357);
    check("donly_a", a_reg, 16'h0999);
    check("donly_pc", pc, 16'h0009);

    // Jump with A written in the same instruction: target is old A
    drive(1'b1, 16'hE000, 16'h0042, 1'b1, 3'b100);
    tick();
    check("jmpold_a", a_reg, 16'h0042);
    check("jmpold_pc", pc, 16'h0999);

    // A-load ignores jmp and dst
    drive(1'b1, 16'h0020, 16'hBEEF, 1'b1, 3'b111);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    check("aign_a", a_reg, 16'h0020);
    check("aign_d", d_reg, 16'h1357);
    check("aign_pc", pc, 16'h099A);
    check("aign_no_store", {15'd0, mb.mem_wr_valid}, 16'd0);

    // Reset during STORE, in the second wait cycle
    mb.mem_wr_ready = 1'b0;
    drive(1'b1, 16'h8000, 16'h5555, 1'b0, 3'b001);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    check("rs_valid", {15'd0, mb.mem_wr_valid}, 16'd1);
    check("rs_addr", mb.mem_wr_addr, 16'h0020);
    tick();                                    // wait cycle 1 done
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_valid_after", {15'd0, mb.mem_wr_valid}, 16'd0);
    check("rs_ready_after", {15'd0, ib.instr_ready}, 16'd1);
    check("rs_a", a_reg, 16'h0000);
    check("rs_d", d_reg, 16'h0000);
    check("rs_pc", pc, 16'h0000);
    check("rs_retired", {15'd0, retired}, 16'd0);
    mb.mem_wr_ready = 1'b1;
    tick();
    check("rs_retired_next", {15'd0, retired}, 16'd0);
    check("rs_valid_next", {15'd0, mb.mem_wr_valid}, 16'd0);

    // PC wrap on the RESET_PC=FFFF instance
    check("wrap_pc_before", pc_w, 16'hFFFF);
    ib_w.instr_valid = 1'b1;
    ib_w.instruction = 16'h0001;
    tick();
    ib_w.instr_valid = 1'b0;
    check("wrap_pc", pc_w, 16'h0000);
    check("wrap_a", a_reg_w, 16'h0001);

`ifdef NGWB_RETIRE_CNT_EN
    // Retire counter wrap: 65537 retirements leave the count at 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_rst", retire_count, 16'd0);
    drive(1'b1, 16'h0001, 16'h0000, 1'b0, 3'b000);
    repeat (65537) tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000);
    tick();
    check("cnt_wrap", retire_count, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ng_writeback.md
# ng_writeback

Register-commit and program-counter unit for the nandgame core, sitting downstream of the combinational instruction handler. Each cycle it accepts one instruction together with the handler's ALU result, jump flag and destination mask. It commits results to the A and D registers and advances or redirects the PC. It issues `*A` stores to data memory over a valid/ready write port, stalling instruction acceptance until each store completes. It also sources the `a_reg`, `d_reg` and `pc` values that feed back into the handler and fetch.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `instr_valid`  in  1: instruction and handler outputs are present this cycle.
- `instr_ready`  out  1: unit can accept; transfer occurs when `instr_valid & instr_ready` at the edge.
- `instruction`  in  16: raw instruction word; bit 15 = 1 is a compute (C) instruction, bit 15 = 0 is an A-load.
- `alu_out`  in  16: handler ALU result.
- `jmp`  in  1: handler jump condition.
- `dst`  in  3: handler destination mask; bit 2 = A, bit 1 = D, bit 0 = `*A`.
- `a_reg`  out  16: A register.
- `d_reg`  out  16: D register.
- `pc`  out  16: program counter.
- `mem_wr_valid`  out  1: store request pending.
- `mem_wr_ready`  in  1: memory accepts the store.
- `mem_wr_addr`  out  16: store address.
- `mem_wr_data`  out  16: store data.
- `retired`  out  1: one-cycle pulse per completed instruction.

## Operation
- Two states:
  - **EXEC**: `instr_ready` = 1.
  - **STORE**: `instr_ready` = 0, waiting for the memory handshake.
- On accept of an A-load (bit 15 = 0):
  - A ← `instruction`.
  - D is unchanged.
  - PC ← PC+1.
  - `jmp` and `dst` are ignored.
- On accept of a C-instruction (bit 15 = 1):
  - If `dst[2]`: A ← `alu_out`.
  - If `dst[1]`: D ← `alu_out`.
  - PC ← old A if `jmp`, else PC+1.
  - If `dst[0]`: `mem_wr_addr` ← old A, `mem_wr_data` ← `alu_out`, `mem_wr_valid` ← 1, go to STORE.
  - Instruction bits 14:13 and 11 are ignored.
- "Old A" means the value of A before this instruction's update. This governs both the store address and the jump target, even when `dst[2]` is set in the same instruction.
- In STORE:
  - `mem_wr_valid`, `mem_wr_addr` and `mem_wr_data` are held stable until `mem_wr_valid & mem_wr_ready` at an edge.
  - After the handshake, `mem_wr_valid` ← 0 and state ← EXEC.
- PC arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000.
- `retired`:
  - Pulses in the cycle after the accept edge when no store is issued.
  - Pulses in the cycle after the handshake edge when a store is issued.
- With no `instr_valid`, registers hold their values.

## Timing
- Reset values:
  - A = 0, D = 0, PC = `RESET_PC`.
  - `mem_wr_valid` = 0, `mem_wr_addr` = 0, `mem_wr_data` = 0.
  - `retired` = 0, state = EXEC, `instr_ready` = 1.
- Register updates are visible one cycle after the accept edge.
- `mem_wr_valid` asserts in the cycle after accept.
- Minimum store occupancy is 1 cycle in STORE (`mem_wr_ready` held high). Each wait cycle adds one.
- Back-to-back non-store instructions are accepted every cycle.
- `mem_wr_ready` high while `mem_wr_valid` is low has no effect.
- `instr_valid` while in STORE is ignored; the producer holds the instruction until `instr_ready`.
- Reset during STORE:
  - The pending store is abandoned, with no handshake required.
  - `mem_wr_valid` is 0 from the next cycle.
  - No `retired` pulse is produced.
- Reset has priority over any simultaneous accept or handshake.

## Configuration
- `NGWB_RETIRE_CNT_EN` defined:
  - Adds output `retire_count` (16 bits).
  - Resets to 0 and increments on each `retired` pulse.
  - Wraps from 16'hFFFF to 16'h0000.
- Not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **A-load:** after reset, accept `instruction`=16'h1234.
  - Next cycle: A=16'h1234, PC=`RESET_PC`+1, `retired` pulses, no store.
- **C-instruction with A and D destinations:** with A=5, accept `instruction`=16'h8000, `dst`=3'b110, `alu_out`=16'h00AA, `jmp`=1.
  - Next cycle: A=16'h00AA, D=16'h00AA, PC=5.
- **Store with dual destination:** with A=16'h0010, `dst`=3'b101, `alu_out`=16'h0077, `mem_wr_ready` held low 3 cycles then high.
  - A becomes 16'h0077.
  - `mem_wr_addr`=16'h0010 and `mem_wr_data`=16'h0077, held stable.
  - `instr_ready`=0 until the handshake.
  - `retired` pulses one cycle after the handshake.
- **Reset during STORE:** assert `rst` in the second wait cycle.
  - Next cycle: `mem_wr_valid`=0, `instr_ready`=1, A/D/PC at reset values, no `retired` pulse.
- **PC wrap:** `RESET_PC`=16'hFFFF, accept one non-jumping instruction.
  - PC=16'h0000.
- **Retire counter wrap** (`NGWB_RETIRE_CNT_EN` defined): retire 65537 instructions.
  - `retire_count`=1.
